// File: rtl/car_position_ctrl.sv
// Player car motion: per-frame velocity update with friction and saturation,
// position integration and screen-edge clamping for the sprite draw stage.
module car_position_ctrl #(
    parameter int H_RES     = 1024,
    parameter int V_RES     = 768,
    parameter int CAR_W     = 64,
    parameter int CAR_H     = 64,
    parameter int X_INIT    = 480,
    parameter int Y_INIT    = 600,
    parameter int MAX_SPEED = 8,
    parameter int ACCEL     = 1
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               enable,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [10:0]        xpos,
    output logic [10:0]        ypos,
    output logic signed [4:0]  vx,
    output logic signed [4:0]  vy,
    output logic               bump
);

    localparam logic [10:0] X_LIM = 11'(H_RES - CAR_W);
    localparam logic [10:0] Y_LIM = 11'(V_RES - CAR_H);
    localparam logic signed [5:0] ACC  = 6'(ACCEL);
    localparam logic signed [5:0] VMAX = 6'(MAX_SPEED);

    typedef enum logic [1:0] {IDLE, VEL, POS} state_t;

    state_t state, state_nxt;

    logic [3:0]        btn_meta, btn_sync;
    logic              btn_l, btn_r, btn_u, btn_d;
    logic              vsync_q, tick;
    logic              vel_en, pos_en;
    logic signed [4:0] vx_nxt, vy_nxt;
    logic [10:0]       xpos_nxt, ypos_nxt;
    logic              x_hit, y_hit;

    function automatic logic signed [4:0] vel_step(
        input logic signed [4:0] v,
        input logic              inc,
        input logic              dec,
        input logic              en
    );
        logic signed [5:0] w;
        w = {v[4], v};
        if (!en)
            w = '0;
        else if (inc && !dec) begin
            w = w + ACC;
            if (w > VMAX) w = VMAX;
        end else if (dec && !inc) begin
            w = w - ACC;
            if (w < -VMAX) w = -VMAX;
        end else if (w > 6'sd0)
            w = w - 6'sd1;
        else if (w < 6'sd0)
            w = w + 6'sd1;
        return w[4:0];
    endfunction

    // Result is {clamped, new_pos}; sum is done in 13 bits so negatives never wrap.
    function automatic logic [11:0] pos_step(
        input logic [10:0]       p,
        input logic signed [4:0] v,
        input logic [10:0]       lim
    );
        logic signed [12:0] n;
        n = $signed({2'b00, p}) + $signed({{8{v[4]}}, v});
        if (n < 13'sd0)
            return {1'b1, 11'd0};
        else if (n > $signed({2'b00, lim}))
            return {1'b1, lim};
        else
            return {1'b0, n[10:0]};
    endfunction

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            vsync_q  <= 1'b0;
        end else begin
            btn_meta <= {btn_down, btn_up, btn_right, btn_left};
            btn_sync <= btn_meta;
            vsync_q  <= vsync_in;
        end
    end

    assign {btn_d, btn_u, btn_r, btn_l} = btn_sync;
    assign tick = vsync_in & ~vsync_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (tick) state_nxt = VEL;
            VEL:     state_nxt = POS;
            POS:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vel_en = 1'b0;
        pos_en = 1'b0;
        unique case (state)
            VEL:     vel_en = 1'b1;
            POS:     pos_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        vx_nxt = vel_step(vx, btn_r, btn_l, enable);
        vy_nxt = vel_step(vy, btn_d, btn_u, enable);
        {x_hit, xpos_nxt} = pos_step(xpos, vx, X_LIM);
        {y_hit, ypos_nxt} = pos_step(ypos, vy, Y_LIM);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            xpos <= 11'(X_INIT);
            ypos <= 11'(Y_INIT);
            vx   <= '0;
            vy   <= '0;
            bump <= 1'b0;
        end else begin
            bump <= 1'b0;
            if (vel_en) begin
                vx <= vx_nxt;
                vy <= vy_nxt;
            end
            if (pos_en) begin
                xpos <= xpos_nxt;
                ypos <= ypos_nxt;
                if (x_hit) vx <= '0;
                if (y_hit) vy <= '0;
                bump <= x_hit | y_hit;
            end
        end
    end

endmodule

// File: tb/tb_car_position_ctrl.sv
// Directed bench for car_position_ctrl: reset, acceleration, friction,
// wall clamping, enable gating and reset in the middle of a frame.
module tb_car_position_ctrl;

    logic              pclk = 1'b0;
    logic              rst = 1'b0;
    logic              vsync_in = 1'b0;
    logic              enable = 1'b0;
    logic              btn_left = 1'b0;
    logic              btn_right = 1'b0;
    logic              btn_up = 1'b0;
    logic              btn_down = 1'b0;
    logic [10:0]       xpos, ypos;
    logic signed [4:0] vx, vy;
    logic              bump;

    int checks = 0;
    int errors = 0;

    logic signed [4:0] mid_vx, mid_vy, end_vx, end_vy;
    logic [10:0]       mid_x, mid_y;
    logic              mid_bump, end_bump, after_bump;

    car_position_ctrl dut (
        .pclk      (pclk),
        .rst       (rst),
        .vsync_in  (vsync_in),
        .enable    (enable),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .xpos      (xpos),
        .ypos      (ypos),
        .vx        (vx),
        .vy        (vy),
        .bump      (bump)
    );

    always #5 pclk = ~pclk;

    task automatic settle();
        repeat (3) @(negedge pclk);
    endtask

    // One frame: tick seen at edge E0, VEL at E1, POS at E2, bump during the next cycle.
    task automatic frame();
        @(negedge pclk);
        vsync_in = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        mid_vx = vx;
        mid_vy = vy;
        mid_x = xpos;
        mid_y = ypos;
        mid_bump = bump;
        @(posedge pclk);
        #1;
        end_vx = vx;
        end_vy = vy;
        end_bump = bump;
        @(posedge pclk);
        #1;
        after_bump = bump;
        @(negedge pclk);
        vsync_in = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b0;
        vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            btn_left = i[0];
            btn_right = ~i[0];
            btn_up = i[1];
            btn_down = ~i[1];
        end
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        checks++; if (xpos !== 11'd480) begin errors++; $display("FAIL reset_x got %0d exp 480", xpos); end
        checks++; if (ypos !== 11'd600) begin errors++; $display("FAIL reset_y got %0d exp 600", ypos); end
        checks++; if (vx !== 5'sd0) begin errors++; $display("FAIL reset_vx got %0d exp 0", vx); end
        checks++; if (vy !== 5'sd0) begin errors++; $display("FAIL reset_vy got %0d exp 0", vy); end
        checks++; if (bump !== 1'b0) begin errors++; $display("FAIL reset_bump got %0b exp 0", bump); end
        enable = 1'b1;
        btn_right = 1'b1;
        repeat (6) @(negedge pclk);
        checks++; if (xpos !== 11'd480) begin errors++; $display("FAIL reset_hold_x got %0d exp 480", xpos); end
        checks++; if (vx !== 5'sd0) begin errors++; $display("FAIL reset_hold_vx got %0d exp 0", vx); end
    endtask

    task automatic test_accel();
        int ev[10];
        int ex[10];
        int prev;
        ev = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
        ex = '{481, 483, 486, 490, 495, 501, 508, 516, 524, 532};
        prev = 480;
        for (int i = 0; i < 10; i++) begin
            frame();
            checks++; if (mid_vx !== 5'(ev[i])) begin errors++; $display("FAIL accel_vx[%0d] got %0d exp %0d", i, mid_vx, ev[i]); end
            checks++; if (mid_x !== 11'(prev)) begin errors++; $display("FAIL accel_x_hold[%0d] got %0d exp %0d", i, mid_x, prev); end
            checks++; if (xpos !== 11'(ex[i])) begin errors++; $display("FAIL accel_x[%0d] got %0d exp %0d", i, xpos, ex[i]); end
            checks++; if (end_bump !== 1'b0) begin errors++; $display("FAIL accel_bump[%0d] got %0b exp 0", i, end_bump); end
            prev = ex[i];
        end
        checks++; if (ypos !== 11'd600) begin errors++; $display("FAIL accel_y got %0d exp 600", ypos); end
    endtask

    task automatic test_friction();
        int ev[9];
        int ex[9];
        int bv[6];
        int bx[6];
        ev = '{7, 6, 5, 4, 3, 2, 1, 0, 0};
        ex = '{539, 545, 550, 554, 557, 559, 560, 560, 560};
        btn_right = 1'b0;
        settle();
        for (int i = 0; i < 9; i++) begin
            frame();
            checks++; if (mid_vx !== 5'(ev[i])) begin errors++; $display("FAIL fric_vx[%0d] got %0d exp %0d", i, mid_vx, ev[i]); end
            checks++; if (xpos !== 11'(ex[i])) begin errors++; $display("FAIL fric_x[%0d] got %0d exp %0d", i, xpos, ex[i]); end
        end
        bv = '{1, 2, 3, 2, 1, 0};
        bx = '{561, 563, 566, 568, 569, 569};
        btn_right = 1'b1;
        settle();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                btn_left = 1'b1;
                settle();
            end
            frame();
            checks++; if (mid_vx !== 5'(bv[i])) begin errors++; $display("FAIL both_vx[%0d] got %0d exp %0d", i, mid_vx, bv[i]); end
            checks++; if (xpos !== 11'(bx[i])) begin errors++; $display("FAIL both_x[%0d] got %0d exp %0d", i, xpos, bx[i]); end
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic test_right_wall();
        do_reset();
        enable = 1'b1;
        btn_left = 1'b1;
        settle();
        frame();
        btn_left = 1'b0;
        settle();
        frame();
        checks++; if (xpos !== 11'd479) begin errors++; $display("FAIL wall_prep_x got %0d exp 479", xpos); end
        btn_right = 1'b1;
        settle();
        repeat (63) frame();
        checks++; if (xpos !== 11'd955) begin errors++; $display("FAIL wall_start_x got %0d exp 955", xpos); end
        checks++; if (end_vx !== 5'sd8) begin errors++; $display("FAIL wall_start_vx got %0d exp 8", end_vx); end
        frame();
        checks++; if (mid_vx !== 5'sd8) begin errors++; $display("FAIL wall1_mid_vx got %0d exp 8", mid_vx); end
        checks++; if (mid_bump !== 1'b0) begin errors++; $display("FAIL wall1_mid_bump got %0b exp 0", mid_bump); end
        checks++; if (xpos !== 11'd960) begin errors++; $display("FAIL wall1_x got %0d exp 960", xpos); end
        checks++; if (end_vx !== 5'sd0) begin errors++; $display("FAIL wall1_vx got %0d exp 0", end_vx); end
        checks++; if (end_bump !== 1'b1) begin errors++; $display("FAIL wall1_bump got %0b exp 1", end_bump); end
        checks++; if (after_bump !== 1'b0) begin errors++; $display("FAIL wall1_bump_len got %0b exp 0", after_bump); end
        frame();
        checks++; if (mid_vx !== 5'sd1) begin errors++; $display("FAIL wall2_mid_vx got %0d exp 1", mid_vx); end
        checks++; if (xpos !== 11'd960) begin errors++; $display("FAIL wall2_x got %0d exp 960", xpos); end
        checks++; if (end_vx !== 5'sd0) begin errors++; $display("FAIL wall2_vx got %0d exp 0", end_vx); end
        checks++; if (end_bump !== 1'b1) begin errors++; $display("FAIL wall2_bump got %0b exp 1", end_bump); end
        checks++; if (after_bump !== 1'b0) begin errors++; $display("FAIL wall2_bump_len got %0b exp 0", after_bump); end
        btn_right = 1'b0;
    endtask

    task automatic test_top_wall();
        btn_up = 1'b1;
        settle();
        repeat (78) frame();
        checks++; if (ypos !== 11'd4) begin errors++; $display("FAIL top_start_y got %0d exp 4", ypos); end
        checks++; if (end_vy !== -5'sd8) begin errors++; $display("FAIL top_start_vy got %0d exp -8", end_vy); end
        checks++; if (end_bump !== 1'b0) begin errors++; $display("FAIL top_start_bump got %0b exp 0", end_bump); end
        frame();
        checks++; if (mid_vy !== -5'sd8) begin errors++; $display("FAIL top1_mid_vy got %0d exp -8", mid_vy); end
        checks++; if (ypos !== 11'd0) begin errors++; $display("FAIL top1_y got %0d exp 0", ypos); end
        checks++; if (end_vy !== 5'sd0) begin errors++; $display("FAIL top1_vy got %0d exp 0", end_vy); end
        checks++; if (end_bump !== 1'b1) begin errors++; $display("FAIL top1_bump got %0b exp 1", end_bump); end
        frame();
        checks++; if (mid_vy !== -5'sd1) begin errors++; $display("FAIL top2_mid_vy got %0d exp -1", mid_vy); end
        checks++; if (ypos !== 11'd0) begin errors++; $display("FAIL top2_y got %0d exp 0", ypos); end
        checks++; if (end_bump !== 1'b1) begin errors++; $display("FAIL top2_bump got %0b exp 1", end_bump); end
        checks++; if (xpos !== 11'd960) begin errors++; $display("FAIL top_x got %0d exp 960", xpos); end
        btn_up = 1'b0;
    endtask

    task automatic test_enable();
        btn_left = 1'b1;
        btn_down = 1'b1;
        settle();
        frame();
        frame();
        checks++; if (xpos !== 11'd957) begin errors++; $display("FAIL en_pre_x got %0d exp 957", xpos); end
        checks++; if (ypos !== 11'd3) begin errors++; $display("FAIL en_pre_y got %0d exp 3", ypos); end
        checks++; if (end_vx !== -5'sd2) begin errors++; $display("FAIL en_pre_vx got %0d exp -2", end_vx); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame();
            checks++; if (mid_vx !== 5'sd0) begin errors++; $display("FAIL en_vx[%0d] got %0d exp 0", i, mid_vx); end
            checks++; if (mid_vy !== 5'sd0) begin errors++; $display("FAIL en_vy[%0d] got %0d exp 0", i, mid_vy); end
            checks++; if (xpos !== 11'd957) begin errors++; $display("FAIL en_x[%0d] got %0d exp 957", i, xpos); end
            checks++; if (ypos !== 11'd3) begin errors++; $display("FAIL en_y[%0d] got %0d exp 3", i, ypos); end
        end
        btn_down = 1'b0;
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        settle();
        @(negedge pclk);
        vsync_in = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        checks++; if (vx !== -5'sd1) begin errors++; $display("FAIL rmid_vel_vx got %0d exp -1", vx); end
        checks++; if (xpos !== 11'd957) begin errors++; $display("FAIL rmid_vel_x got %0d exp 957", xpos); end
        rst = 1'b0;
        #1;
        checks++; if (xpos !== 11'd480) begin errors++; $display("FAIL rmid_x got %0d exp 480", xpos); end
        checks++; if (ypos !== 11'd600) begin errors++; $display("FAIL rmid_y got %0d exp 600", ypos); end
        checks++; if (vx !== 5'sd0) begin errors++; $display("FAIL rmid_vx got %0d exp 0", vx); end
        checks++; if (bump !== 1'b0) begin errors++; $display("FAIL rmid_bump got %0b exp 0", bump); end
        @(negedge pclk);
        vsync_in = 1'b0;
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        repeat (5) @(negedge pclk);
        checks++; if (xpos !== 11'd480) begin errors++; $display("FAIL rmid_after_x got %0d exp 480", xpos); end
        checks++; if (bump !== 1'b0) begin errors++; $display("FAIL rmid_after_bump got %0b exp 0", bump); end
        frame();
        checks++; if (mid_vx !== -5'sd1) begin errors++; $display("FAIL rmid_resume_vx got %0d exp -1", mid_vx); end
        checks++; if (xpos !== 11'd479) begin errors++; $display("FAIL rmid_resume_x got %0d exp 479", xpos); end
        btn_left = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accel();
        test_friction();
        test_right_wall();
        test_top_wall();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
